// File: rtl/inert_chan_display.sv
// Bring-up display for N inertial channels: calibration with timeout,
// then one selectable channel shown on LEDs, with an error blink mode.
module inert_chan_display #(
  parameter int NUM_CH  = 3,
  parameter int DATA_W  = 16,
  parameter int LED_W   = 8,
  parameter int LSB_OFS = 1,
  parameter int SAT     = 0,
  parameter int CAL_TO  = 1048576,
  localparam int SW     = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     next_btn,
  input  logic                     prev_btn,
  input  logic                     cal_done,
  input  logic                     vld,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     strt_cal,
  output logic [SW-1:0]            sel,
  output logic [LED_W-1:0]         led,
  output logic                     cal_err
);

  localparam int CW = $clog2(CAL_TO);
  localparam int BW = 20;
  localparam logic signed [DATA_W-1:0] MAXV =
    DATA_W'((2 ** (LED_W - 1)) - 1);
  localparam logic signed [DATA_W-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {
    S_CAL,
    S_SHOW,
    S_ERR
  } st_t;

  st_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [LED_W-1:0] led_q, led_d;
  logic strt_q, strt_d;
  logic next_q, prev_q;
  logic nxt_e, prv_e, tmo;
  logic [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] y;
  logic [LED_W-1:0] fv;

  assign nxt_e = next_btn & ~next_q;
  assign prv_e = prev_btn & ~prev_q;
  assign tmo   = (cnt_q == CW'(CAL_TO - 1));

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q   <= S_CAL;
      cnt_q  <= '0;
      blk_q  <= '0;
      sel_q  <= '0;
      led_q  <= '0;
      strt_q <= 1'b0;
      next_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      blk_q  <= blk_d;
      sel_q  <= sel_d;
      led_q  <= led_d;
      strt_q <= strt_d;
      next_q <= next_btn;
      prev_q <= prev_btn;
    end
  end

  // Next state: cal_done beats the timeout, next edge retries from ERR
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_CAL: begin
        if (cal_done) st_d = S_SHOW;
        else if (tmo) st_d = S_ERR;
      end
      S_SHOW: st_d = S_SHOW;
      S_ERR: begin
        if (nxt_e) st_d = S_CAL;
      end
      default: st_d = S_CAL;
    endcase
  end

  // Channel select with wrap; simultaneous edges cancel
  always_comb begin
    sel_d = sel_q;
    if (st_q == S_CAL) begin
      sel_d = '0;
    end else if (st_q == S_SHOW) begin
      if (nxt_e && !prv_e)
        sel_d = (sel_q == SW'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
      else if (prv_e && !nxt_e)
        sel_d = (sel_q == '0) ? SW'(NUM_CH - 1) : sel_q - 1'b1;
    end
  end

  // Channel mux and LED mapping (slice or shift-and-clamp)
  always_comb begin
    x = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (sel_d == SW'(i)) x = ch_data[i*DATA_W +: DATA_W];
    y  = $signed(x) >>> LSB_OFS;
    fv = x[LSB_OFS +: LED_W];
    if (SAT != 0) begin
      if (y > MAXV)      fv = {1'b0, {(LED_W-1){1'b1}}};
      else if (y < MINV) fv = {1'b1, {(LED_W-1){1'b0}}};
      else               fv = y[LED_W-1:0];
    end
  end

  // Counters, start pulse and LED register next values
  always_comb begin
    cnt_d  = (st_q == S_CAL && !cal_done && !tmo) ? cnt_q + 1'b1 : '0;
    blk_d  = (st_q == S_ERR) ? blk_q + 1'b1 : '0;
    strt_d = (st_q == S_CAL) && (cnt_q == '0);
    led_d  = led_q;
    unique case (st_q)
      S_CAL: begin
        if (cal_done) led_d = fv;
        else if (tmo) led_d = '1;
        else          led_d = '0;
      end
      S_SHOW: begin
        if (vld || sel_d != sel_q) led_d = fv;
      end
      S_ERR: begin
        if (nxt_e)             led_d = '0;
        else if (blk_q == '1)  led_d = ~led_q;
      end
      default: led_d = '0;
    endcase
  end

  // Outputs straight from registers
  always_comb begin
    strt_cal = strt_q;
    sel      = sel_q;
    led      = led_q;
    cal_err  = (st_q == S_ERR);
  end

endmodule

// File: tb/tb_inert_chan_display.sv
// Scoreboard bench: a behavioural model queues expected outputs per edge,
// a negedge monitor pops and compares against a slice and a clamp DUT.
module tb_inert_chan_display;

  localparam int NCH = 3;
  localparam int DW  = 16;
  localparam int CTO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, next_btn, prev_btn, cal_done, vld;
  logic [NCH*DW-1:0] ch_data;
  logic s0, s1, e0, e1;
  logic [1:0] sel0, sel1;
  logic [7:0] led0, led1;

  inert_chan_display #(
    .NUM_CH(NCH), .DATA_W(DW), .LED_W(8), .LSB_OFS(1),
    .SAT(0), .CAL_TO(CTO)
  ) d0 (
    .clk(clk), .rst_n(rst_n), .next_btn(next_btn),
    .prev_btn(prev_btn), .cal_done(cal_done), .vld(vld),
    .ch_data(ch_data), .strt_cal(s0), .sel(sel0),
    .led(led0), .cal_err(e0)
  );

  inert_chan_display #(
    .NUM_CH(NCH), .DATA_W(DW), .LED_W(8), .LSB_OFS(1),
    .SAT(1), .CAL_TO(CTO)
  ) d1 (
    .clk(clk), .rst_n(rst_n), .next_btn(next_btn),
    .prev_btn(prev_btn), .cal_done(cal_done), .vld(vld),
    .ch_data(ch_data), .strt_cal(s1), .sel(sel1),
    .led(led1), .cal_err(e1)
  );

  typedef struct packed {
    logic       strt;
    logic [1:0] sel;
    logic [7:0] l0;
    logic [7:0] l1;
    logic       err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // model: 0 calibrating, 1 showing, 2 error
  int mode, ccyc, ecyc, m_sel, m_l0, m_l1;
  bit m_strt, m_err, pn, pp;

  function automatic int f_slice(input logic [15:0] v);
    return (int'(v) >> 1) & 255;
  endfunction

  function automatic int f_clamp(input logic [15:0] v);
    int s;
    s = int'($signed(v)) >>> 1;
    if (s > 127) return 127;
    if (s < -128) return 128;
    return s & 255;
  endfunction

  task automatic load(input int c);
    logic [15:0] w;
    w = ch_data[c*DW +: DW];
    m_l0 = f_slice(w);
    m_l1 = f_clamp(w);
  endtask

  task automatic model_edge();
    bit ne, pe;
    int old;
    if (!rst_n) begin
      mode = 0; ccyc = 0; ecyc = 0; m_sel = 0;
      m_l0 = 0; m_l1 = 0; m_strt = 0; m_err = 0;
      pn = 0; pp = 0;
    end else begin
      ne = next_btn && !pn;
      pe = prev_btn && !pp;
      case (mode)
        0: begin
          m_strt = (ccyc == 0);
          if (cal_done) begin
            mode = 1; m_sel = 0; ccyc = 0; load(0);
          end else if (ccyc == CTO - 1) begin
            mode = 2; m_err = 1; ccyc = 0; ecyc = 0;
            m_l0 = 255; m_l1 = 255;
          end else begin
            ccyc++; m_l0 = 0; m_l1 = 0;
          end
        end
        1: begin
          m_strt = 0;
          old = m_sel;
          if (ne && !pe) m_sel = (m_sel + 1) % NCH;
          else if (pe && !ne) m_sel = (m_sel + NCH - 1) % NCH;
          if (vld || m_sel != old) load(m_sel);
        end
        default: begin
          m_strt = 0;
          if (ne) begin
            mode = 0; m_err = 0; ccyc = 0; m_l0 = 0; m_l1 = 0;
          end else begin
            ecyc++;
            if (ecyc % (1 << 20) == 0) begin
              m_l0 = 255 - m_l0; m_l1 = 255 - m_l1;
            end
          end
        end
      endcase
      pn = next_btn;
      pp = prev_btn;
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    e.strt = m_strt;
    e.sel  = 2'(m_sel);
    e.l0   = 8'(m_l0);
    e.l1   = 8'(m_l1);
    e.err  = m_err;
    q.push_back(e);
  endtask

  task automatic cyc(input logic r, nb, pb, cd, v,
                     input logic [NCH*DW-1:0] d);
    rst_n = r; next_btn = nb; prev_btn = pb;
    cal_done = cd; vld = v; ch_data = d;
    step();
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Monitor: one expectation per clock, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("strt0", 32'(s0), 32'(e.strt));
        chk("strt1", 32'(s1), 32'(e.strt));
        chk("sel0", 32'(sel0), 32'(e.sel));
        chk("sel1", 32'(sel1), 32'(e.sel));
        chk("led_slice", 32'(led0), 32'(e.l0));
        chk("led_clamp", 32'(led1), 32'(e.l1));
        chk("err0", 32'(e0), 32'(e.err));
        chk("err1", 32'(e1), 32'(e.err));
      end
    end
  end

  task automatic rand_show(input int n);
    logic [NCH*DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = ch_data;
      if ($urandom_range(0, 3) == 0)
        d = {$urandom(), $urandom()};
      cyc(1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, d);
    end
  endtask

  initial begin
    logic [NCH*DW-1:0] d;
    rst_n = 0; next_btn = 0; prev_btn = 0;
    cal_done = 0; vld = 0;
    d = {16'hF00F, 16'h1234, 16'h0154};
    ch_data = d;
    repeat (3) cyc(0, 0, 0, 0, 0, d);
    repeat (10) cyc(1, 0, 0, 0, 0, d);
    repeat (3) cyc(1, 0, 0, 1, 0, d);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 1, 0, d);
      cyc(1, 0, 0, 1, 0, d);
    end
    cyc(1, 0, 1, 0, 0, d);
    cyc(1, 0, 0, 0, 0, d);
    cyc(1, 1, 1, 0, 0, d);
    cyc(1, 0, 0, 0, 0, d);
    d[15:0] = 16'h0002;
    repeat (2) cyc(1, 0, 0, 0, 0, d);
    cyc(1, 0, 0, 0, 1, d);
    cyc(1, 0, 0, 0, 0, d);
    d[15:0] = 16'h7FFF; cyc(1, 0, 0, 0, 1, d); cyc(1, 0, 0, 0, 0, d);
    d[15:0] = 16'h8000; cyc(1, 0, 0, 0, 1, d); cyc(1, 0, 0, 0, 0, d);
    d[15:0] = 16'hFFFC; cyc(1, 0, 0, 0, 1, d); cyc(1, 0, 0, 0, 0, d);
    rand_show(300);
    d = ch_data;
    repeat (3) cyc(0, 1, 0, 0, 0, d);
    repeat (20) cyc(1, 0, 0, 0, 0, d);
    cyc(1, 0, 1, 0, 0, d);
    repeat (2) cyc(1, 0, 0, 0, 0, d);
    cyc(1, 1, 0, 0, 0, d);
    repeat (4) cyc(1, 1, 0, 0, 0, d);
    cyc(1, 0, 0, 1, 0, d);
    rand_show(300);
    cyc(1, 0, 0, 0, 0, ch_data);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
